// File: rtl/spi_master_rx_ctrl.sv
// SPI master receive controller.
// Samples SDI (one lane in std mode, four lanes in quad mode) on rx_edge strobes,
// packs the bits MSB first into 32-bit words and offers each word on a
// valid/ready port. When the consumer cannot take a finished word, SCK is
// gated through clk_en_o until the word has been accepted.
module spi_master_rx_ctrl #(
   parameter int unsigned CNT_W    = 16,
   parameter int unsigned RST_TRGT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             rx_edge,
   output logic             rx_done,
   input  logic             sdi0,
   input  logic             sdi1,
   input  logic             sdi2,
   input  logic             sdi3,
   input  logic             en_quad_in,
   input  logic [CNT_W-1:0] counter_in,
   input  logic             counter_in_upd,
   output logic [31:0]      data,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             clk_en_o
);

   localparam int unsigned WORD_W = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RECV = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t              r_state;
   logic [CNT_W-1:0]    r_counter;
   logic [CNT_W-1:0]    r_target;
   logic [WORD_W-1:0]   r_sr;
   logic [WORD_W-1:0]   r_data;
   logic                r_data_valid;
   logic                r_rx_done;
   logic                r_clk_en;
   logic                r_pend_last;

   logic [WORD_W-1:0]   w_sr_shift;
   logic                w_word_end;
   logic                w_last;
   logic                w_out_free;
   logic                w_hs;

   // Shift register value including the bits sampled on this edge
   assign w_sr_shift = en_quad_in ? {r_sr[WORD_W-5:0], sdi3, sdi2, sdi1, sdi0}
                                  : {r_sr[WORD_W-2:0], sdi0};
   assign w_word_end = en_quad_in ? (r_counter[2:0] == 3'd7) : (r_counter[4:0] == 5'd31);
   assign w_last     = (r_counter == (r_target - CNT_W'(1)));
   assign w_out_free = !r_data_valid || data_ready;
   assign w_hs       = r_data_valid && data_ready;

   assign data       = r_data;
   assign data_valid = r_data_valid;
   assign rx_done    = r_rx_done;
   assign clk_en_o   = r_clk_en;

   // Transfer length in shift units; reloadable in any state
   always_ff @(posedge clk) begin
      if (rst) begin
         r_target <= CNT_W'(RST_TRGT);
      end else if (counter_in_upd) begin
         r_target <= en_quad_in ? (counter_in >> 2) : counter_in;
      end
   end

   // Receive FSM: sampling, word assembly, output handshake and SCK gating
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_counter    <= '0;
         r_sr         <= '0;
         r_data       <= '0;
         r_data_valid <= 1'b0;
         r_rx_done    <= 1'b0;
         r_clk_en     <= 1'b0;
         r_pend_last  <= 1'b0;
      end else begin
         r_rx_done <= 1'b0;
         // consumed word; a load below in the same cycle keeps valid high
         if (w_hs) begin
            r_data_valid <= 1'b0;
         end
         case (r_state)
            S_IDLE: begin
               r_clk_en <= 1'b0;
               if (en) begin
                  if (r_target != '0) begin
                     r_state   <= S_RECV;
                     r_counter <= '0;
                     r_sr      <= '0;
                     r_clk_en  <= 1'b1;
                  end else begin
                     r_rx_done <= 1'b1;
                  end
               end
            end
            S_RECV: begin
               if (rx_edge) begin
                  r_counter <= r_counter + CNT_W'(1);
                  if (w_word_end || w_last) begin
                     if (w_out_free) begin
                        r_data       <= w_sr_shift;
                        r_data_valid <= 1'b1;
                        r_sr         <= '0;
                        if (w_last) begin
                           r_rx_done <= 1'b1;
                           r_counter <= '0;
                           r_state   <= S_IDLE;
                           r_clk_en  <= 1'b0;
                        end
                     end else begin
                        // consumer still holds the previous word: park this one
                        r_sr        <= w_sr_shift;
                        r_pend_last <= w_last;
                        r_state     <= S_WAIT;
                        r_clk_en    <= 1'b0;
                     end
                  end else begin
                     r_sr <= w_sr_shift;
                  end
               end
            end
            S_WAIT: begin
               if (w_out_free) begin
                  r_data       <= r_sr;
                  r_data_valid <= 1'b1;
                  r_sr         <= '0;
                  if (r_pend_last) begin
                     r_rx_done <= 1'b1;
                     r_counter <= '0;
                     r_state   <= S_IDLE;
                     r_clk_en  <= 1'b0;
                  end else begin
                     r_state  <= S_RECV;
                     r_clk_en <= 1'b1;
                  end
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_clk_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_master_rx_ctrl.sv
// Bench for spi_master_rx_ctrl: directed transfers plus randomized ones, all
// checked against a word-level model built from the sampled unit stream.
module tb_spi_master_rx_ctrl;

   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             rx_edge;
   logic             rx_done;
   logic             sdi0, sdi1, sdi2, sdi3;
   logic             en_quad_in;
   logic [CNT_W-1:0] counter_in;
   logic             counter_in_upd;
   logic [31:0]      data;
   logic             data_valid;
   logic             data_ready;
   logic             clk_en_o;

   int n_checks = 0;
   int n_errors = 0;

   // shift units of the next transfer: bit 0 only in std mode, 4 bits in quad mode
   logic [3:0] g_units[$];

   spi_master_rx_ctrl #(.CNT_W(CNT_W), .RST_TRGT(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .rx_edge        (rx_edge),
      .rx_done        (rx_done),
      .sdi0           (sdi0),
      .sdi1           (sdi1),
      .sdi2           (sdi2),
      .sdi3           (sdi3),
      .en_quad_in     (en_quad_in),
      .counter_in     (counter_in),
      .counter_in_upd (counter_in_upd),
      .data           (data),
      .data_valid     (data_valid),
      .data_ready     (data_ready),
      .clk_en_o       (clk_en_o)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic load_word(input logic [31:0] val, input int nunits, input bit quad);
      logic [31:0] v;
      v = val;
      for (int i = nunits - 1; i >= 0; i--) begin
         if (quad) g_units.push_back(4'((v >> (4 * i)) & 32'hF));
         else      g_units.push_back(4'((v >> i) & 32'h1));
      end
   endtask

   task automatic load_random(input int nunits);
      for (int i = 0; i < nunits; i++) g_units.push_back(4'($urandom_range(0, 15)));
   endtask

   // mode >= 0: data_ready probability in percent
   // mode == -1: ready only on word-completing edges (handshake coincides with load)
   // mode == -2: ready held low until SCK is gated, then high
   task automatic run_xfer(input string name, input bit quad, input bit do_upd,
                           input int mode, input int edge_pct);
      int          n, ups, bpu, idx, done_cnt, stalls, release_cyc, done_cyc;
      bit          seen_stall, timed_out, rdy, edge_now;
      logic [31:0] exp_q[$];
      logic [31:0] got_q[$];
      logic [31:0] u;
      n   = g_units.size();
      ups = quad ? 8 : 32;
      bpu = quad ? 4 : 1;
      for (int w = 0; w < (n + ups - 1) / ups; w++) exp_q.push_back(32'h0);
      for (int i = 0; i < n; i++) begin
         u = quad ? 32'(g_units[i]) : 32'(g_units[i][0]);
         exp_q[i / ups] = (exp_q[i / ups] << bpu) | u;
      end
      idx = 0; done_cnt = 0; stalls = 0; release_cyc = -1; done_cyc = -1;
      seen_stall = 0; timed_out = 1;

      @(negedge clk);
      en_quad_in = quad;
      if (do_upd) begin
         counter_in     = quad ? CNT_W'(n * 4 + int'($urandom_range(0, 3))) : CNT_W'(n);
         counter_in_upd = 1'b1;
         @(negedge clk);
         counter_in_upd = 1'b0;
      end
      en = 1'b1;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(negedge clk);
         en = 1'b0;
         if (rx_done) begin
            done_cnt++;
            done_cyc = cyc;
            check_eq({name, "_done_valid"}, 32'(data_valid), 32'd1);
            check_eq({name, "_done_data"}, data, exp_q[exp_q.size() - 1]);
         end
         if (!clk_en_o && done_cnt == 0) begin
            stalls++;
            if (mode == -2 && !seen_stall) begin
               seen_stall  = 1;
               release_cyc = cyc;
               check_eq({name, "_stall_data"}, data, exp_q[0]);
               check_eq({name, "_stall_valid"}, 32'(data_valid), 32'd1);
            end
         end
         edge_now = clk_en_o && (idx < n) && (int'($urandom_range(0, 99)) < edge_pct);
         if (mode >= 0)       rdy = int'($urandom_range(0, 99)) < mode;
         else if (mode == -1) rdy = (idx >= n) || (edge_now && ((idx % ups) == ups - 1 || idx == n - 1));
         else                 rdy = seen_stall;
         if (edge_now) begin
            rx_edge = 1'b1;
            if (quad) {sdi3, sdi2, sdi1, sdi0} = g_units[idx];
            else begin
               sdi0 = g_units[idx][0];
               {sdi3, sdi2, sdi1} = 3'($urandom_range(0, 7));
            end
            idx++;
         end else begin
            // strobes while SCK is gated must be ignored
            rx_edge = !clk_en_o && ($urandom_range(0, 3) == 0);
            {sdi3, sdi2, sdi1, sdi0} = 4'($urandom_range(0, 15));
         end
         data_ready = rdy;
         if (rdy && data_valid) got_q.push_back(data);
         if (done_cnt > 0 && got_q.size() == exp_q.size()) begin
            timed_out = 0;
            break;
         end
      end
      @(negedge clk);
      data_ready = 1'b0;
      rx_edge    = 1'b0;
      check_eq({name, "_timeout"}, 32'(timed_out), 32'd0);
      check_eq({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
      check_eq({name, "_units"}, 32'(idx), 32'(n));
      check_eq({name, "_nwords"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int w = 0; w < exp_q.size() && w < got_q.size(); w++)
         check_eq($sformatf("%s_word%0d", name, w), got_q[w], exp_q[w]);
      check_eq({name, "_end_valid"}, 32'(data_valid), 32'd0);
      check_eq({name, "_end_clk_en"}, 32'(clk_en_o), 32'd0);
      if (mode == -1) check_eq({name, "_no_stall"}, 32'(stalls), 32'd0);
      if (mode == -2) begin
         check_eq({name, "_saw_stall"}, 32'(seen_stall), 32'd1);
         check_eq({name, "_done_lat"}, 32'(done_cyc), 32'(release_cyc + 1));
      end
      g_units.delete();
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; rx_edge = 1'b0;
      {sdi3, sdi2, sdi1, sdi0} = 4'h0;
      en_quad_in = 1'b0; counter_in = '0; counter_in_upd = 1'b0; data_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_data", data, 32'h0);
      check_eq("rst_valid", 32'(data_valid), 32'd0);
      check_eq("rst_done", 32'(rx_done), 32'd0);
      check_eq("rst_clk_en", 32'(clk_en_o), 32'd0);
      rst = 1'b0;

      load_word(32'hA5C30F96, 32, 0);
      run_xfer("std32", 0, 1, 100, 100);

      load_word(32'h12345678, 8, 1);
      load_word(32'h9ABCDEF0, 8, 1);
      run_xfer("quad64", 1, 1, 100, 100);

      load_random(64);
      run_xfer("std_wait", 0, 1, -2, 100);

      load_word(32'h00000ABC, 12, 0);
      run_xfer("std12", 0, 1, 100, 60);

      // reset in the middle of a transfer
      @(negedge clk);
      en_quad_in = 1'b0; counter_in = CNT_W'(32); counter_in_upd = 1'b1;
      @(negedge clk);
      counter_in_upd = 1'b0; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      repeat (10) begin
         rx_edge = 1'b1; sdi0 = 1'($urandom_range(0, 1));
         @(negedge clk);
      end
      rx_edge = 1'b0; data_ready = 1'b1; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; data_ready = 1'b0;
      check_eq("midrst_data", data, 32'h0);
      check_eq("midrst_valid", 32'(data_valid), 32'd0);
      check_eq("midrst_done", 32'(rx_done), 32'd0);
      check_eq("midrst_clk_en", 32'(clk_en_o), 32'd0);
      // reset target of 8 units is used without reprogramming
      load_random(8);
      run_xfer("post_rst8", 0, 0, 100, 100);
      load_random(32);
      run_xfer("post_rst32", 0, 1, 100, 100);

      load_random(16);
      run_xfer("quad_coinc", 1, 1, -1, 100);
      load_random(96);
      run_xfer("std_coinc", 0, 1, -1, 100);

      // zero-length target (quad, 3 bits -> 0 units): immediate done, no data
      @(negedge clk);
      en_quad_in = 1'b1; counter_in = CNT_W'(3); counter_in_upd = 1'b1;
      @(negedge clk);
      counter_in_upd = 1'b0; en = 1'b1;
      @(negedge clk);
      en = 1'b0;
      check_eq("zero_done", 32'(rx_done), 32'd1);
      check_eq("zero_valid", 32'(data_valid), 32'd0);
      check_eq("zero_clk_en", 32'(clk_en_o), 32'd0);
      @(negedge clk);
      check_eq("zero_done_pulse", 32'(rx_done), 32'd0);

      for (int t = 0; t < 20; t++) begin
         bit q;
         q = 1'($urandom_range(0, 1));
         load_random(int'($urandom_range(1, 100)));
         run_xfer($sformatf("rnd%0d", t), q, 1,
                  int'($urandom_range(20, 100)), int'($urandom_range(20, 100)));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
